fwd_hazard_unit: RTL



---
 rtl/fwd_hazard_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall unit beside ID; scoreboard of FWD_DEPTH stages.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module fwd_hazard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FSEL_W    = $clog2(FWD_DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic                       id_wen,
  input  logic                       id_is_load,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
  input  logic                       flush,
  output logic [NUM_SRC*FSEL_W-1:0]  fwd_sel,
  output logic                       stall,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_fwd_cnt
);

  // A zero-latency build still needs a 1-bit counter field; it simply stays 0.
  localparam int CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT+1) : 1;

  logic              r_v   [1:FWD_DEPTH];
  logic              r_wen [1:FWD_DEPTH];
  logic [REG_AW-1:0] r_rd  [1:FWD_DEPTH];
  logic [CNT_W-1:0]  r_cnt [1:FWD_DEPTH];

  logic [NUM_SRC-1:0] w_blocked;
  logic               w_issue;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_AW-1:0] w_rs;
    logic [FSEL_W-1:0] w_sel;
    logic              w_blk;

    assign w_rs = id_rs[gi*REG_AW +: REG_AW];

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
      w_sel = '0;
      w_blk = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (r_v[k] && r_wen[k] && (r_rd[k] != '0) && (r_rd[k] == w_rs)) begin
          if (r_cnt[k] == '0) begin
            w_sel = FSEL_W'(k);
            w_blk = 1'b0;
          end else begin
            w_sel = '0;
            w_blk = 1'b1;
          end
        end
      end
    end

    assign fwd_sel[gi*FSEL_W +: FSEL_W] = w_sel;
    assign w_blocked[gi]                = w_blk;
  end

  assign stall   = id_valid & ~flush & (|w_blocked);
  assign w_issue = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        r_v[k]   <= 1'b0;
        r_wen[k] <= 1'b0;
        r_rd[k]  <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_v[1]   <= 1'b1;
        r_wen[1] <= id_wen;
        r_rd[1]  <= id_rd;
        r_cnt[1] <= id_is_load ? CNT_W'(LOAD_LAT) : '0;
      end else begin
        r_v[1]   <= 1'b0;
        r_wen[1] <= 1'b0;
        r_rd[1]  <= '0;
        r_cnt[1] <= '0;
      end
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        r_v[k]   <= r_v[k-1];
        r_wen[k] <= r_wen[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_cnt[k] <= (r_cnt[k-1] != '0) ? r_cnt[k-1] - CNT_W'(1) : '0;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam int FNUM_W = $clog2(NUM_SRC+1);

  logic [FNUM_W-1:0] w_fwd_num;
  logic [31:0]       r_perf_stall;
  logic [31:0]       r_perf_fwd;

  always_comb begin
    w_fwd_num = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_sel[i*FSEL_W +: FSEL_W] != '0) w_fwd_num = w_fwd_num + FNUM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_fwd   <= '0;
    end else begin
      if (stall)   r_perf_stall <= r_perf_stall + 32'd1;
      if (w_issue) r_perf_fwd   <= r_perf_fwd + 32'(w_fwd_num);
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_fwd_cnt   = r_perf_fwd;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_fwd_cnt   = 32'd0;
`endif

endmodule
